// File: rtl/peripheral_dbg_pu_riscv_ahb2tl_pkg.sv
// Shared encodings for the debug AHB-Lite to TL-UL bridge: AHB transfer/response
// codes, TL-UL opcodes and the bridge FSM state type.
package peripheral_dbg_pu_riscv_ahb2tl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_PUT_FULL_DATA   = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/peripheral_dbg_pu_riscv_ahb2tl_bridge_if.sv
// AHB-Lite slave port plus TL-UL A/D channels of the bridge, bundled as one interface.
interface peripheral_dbg_pu_riscv_ahb2tl_bridge_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TL_SOURCE_WIDTH = 4
);
  logic                       HSEL;
  logic [ADDR_WIDTH-1:0]      HADDR;
  logic [DATA_WIDTH-1:0]      HWDATA;
  logic [DATA_WIDTH-1:0]      HRDATA;
  logic                       HWRITE;
  logic [2:0]                 HSIZE;
  logic [2:0]                 HBURST;
  logic [3:0]                 HPROT;
  logic [1:0]                 HTRANS;
  logic                       HMASTLOCK;
  logic                       HREADY;
  logic                       HREADYOUT;
  logic                       HRESP;

  logic                       a_valid;
  logic                       a_ready;
  logic [2:0]                 a_opcode;
  logic [2:0]                 a_param;
  logic [2:0]                 a_size;
  logic [TL_SOURCE_WIDTH-1:0] a_source;
  logic [ADDR_WIDTH-1:0]      a_address;
  logic [DATA_WIDTH/8-1:0]    a_mask;
  logic [DATA_WIDTH-1:0]      a_data;

  logic                       d_valid;
  logic                       d_ready;
  logic [2:0]                 d_opcode;
  logic [DATA_WIDTH-1:0]      d_data;
  logic                       d_error;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid and its payload hold steady until then and never wait on ready.
  // slave is the bridge's view; master is the surrounding system (AHB master + TL slave).
  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP,
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_data, d_error,
    output d_ready
  );

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP,
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_data, d_error,
    input  d_ready
  );

endinterface

// File: rtl/peripheral_dbg_pu_riscv_ahb2tl_mask.sv
// Byte-lane mask and size/alignment legality for one AHB transfer.
module peripheral_dbg_pu_riscv_ahb2tl_mask #(
  parameter  int DATA_WIDTH = 32,
  localparam int STRB       = DATA_WIDTH / 8,
  localparam int OFF_W      = $clog2(STRB)
) (
  input  logic [OFF_W-1:0] addr_lo,
  input  logic [2:0]       size,
  output logic [STRB-1:0]  mask,
  output logic             legal
);

  int lo;
  int len;

  always_comb begin
    lo    = int'(addr_lo);
    len   = 1 << size;
    mask  = '0;
    legal = 1'b1;
    for (int i = 0; i < STRB; i++) begin
      if (i >= lo && i < lo + len) mask[i] = 1'b1;
    end
    if (int'(size) > OFF_W) legal = 1'b0;
    // any address bit below the transfer size makes it misaligned
    for (int i = 0; i < OFF_W; i++) begin
      if (i < int'(size) && addr_lo[i]) legal = 1'b0;
    end
  end

endmodule

// File: rtl/peripheral_dbg_pu_riscv_ahb2tl_bridge.sv
// AHB-Lite slave to TL-UL master bridge: one AHB single transfer becomes one
// Get/PutFullData, with a single transaction outstanding.
module peripheral_dbg_pu_riscv_ahb2tl_bridge
  import peripheral_dbg_pu_riscv_ahb2tl_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TL_SOURCE_WIDTH = 4,
  parameter int TL_SOURCE_ID    = 0
) (
  input  logic   HCLK,
  input  logic   HRESETn,
  peripheral_dbg_pu_riscv_ahb2tl_bridge_if.slave bus,
  output state_e dbg_state
);

  localparam int STRB  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(STRB);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic                  hwrite_q;
  logic [2:0]            hsize_q;
  logic [STRB-1:0]       mask_q, mask_c;
  logic                  legal_c;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
  logic                  accept, latch, a_valid, d_ready;

  peripheral_dbg_pu_riscv_ahb2tl_mask #(.DATA_WIDTH(DATA_WIDTH)) u_mask (
    .addr_lo (bus.HADDR[OFF_W-1:0]),
    .size    (bus.HSIZE),
    .mask    (mask_c),
    .legal   (legal_c)
  );

  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      mask_q      <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      if (latch) begin
        haddr_q  <= bus.HADDR;
        hwrite_q <= bus.HWRITE;
        hsize_q  <= bus.HSIZE;
        mask_q   <= mask_c;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    latch       = 1'b0;
    a_valid     = 1'b0;
    d_ready     = 1'b0;
    case (state_q)
      // ERR2 is the second error cycle and already completes the data phase,
      // so it takes a new address phase exactly like IDLE does.
      ST_IDLE, ST_ERR2: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        if (accept) begin
          latch       = 1'b1;
          hreadyout_d = 1'b0;
          if (legal_c) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_ERR1;
            hresp_d = HRESP_ERROR;
          end
        end
      end
      ST_REQ: begin
        a_valid = 1'b1;
        if (bus.a_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        d_ready = 1'b1;
        if (bus.d_valid) begin
          if (bus.d_error) begin
            hresp_d = HRESP_ERROR;
            state_d = ST_ERR1;
          end else begin
            if (!hwrite_q) hrdata_d = bus.d_data;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_OKAY;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_ERR1: begin
        hreadyout_d = 1'b1;
        state_d     = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.HRDATA    = hrdata_q;
  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.a_valid   = a_valid;
  assign bus.a_opcode  = hwrite_q ? TL_PUT_FULL_DATA : TL_GET;
  assign bus.a_param   = 3'd0;
  assign bus.a_size    = hsize_q;
  assign bus.a_source  = TL_SOURCE_WIDTH'(TL_SOURCE_ID);
  assign bus.a_address = haddr_q;
  assign bus.a_mask    = mask_q;
  // HWDATA is held by the master while HREADYOUT is low, so it feeds A directly
  assign bus.a_data    = bus.HWDATA;
  assign bus.d_ready   = d_ready;
  assign dbg_state     = state_q;

  logic unused_bits;
  assign unused_bits = ^{bus.HTRANS[0], bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.d_opcode};

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_ahb2tl_bridge.sv
// Self-checking bench for the AHB-Lite to TL-UL bridge: directed scenarios plus
// randomized transfers against a transaction-level reference model.
module tb_peripheral_dbg_pu_riscv_ahb2tl_bridge;
  import peripheral_dbg_pu_riscv_ahb2tl_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int STRB = DW / 8;

  logic   HCLK = 1'b0;
  logic   HRESETn = 1'b0;
  state_e dbg_state;

  peripheral_dbg_pu_riscv_ahb2tl_bridge_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TL_SOURCE_WIDTH(SW)
  ) bus ();

  // single-slave system: the bus ready is the slave's own ready
  assign bus.HREADY = bus.HREADYOUT;

  peripheral_dbg_pu_riscv_ahb2tl_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TL_SOURCE_WIDTH(SW), .TL_SOURCE_ID(0)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    int              ready_cyc;
    int              low_cyc;
    int              resp_hi;
    int              n_fire;
    int              n_avalid;
    logic [2:0]      opcode;
    logic [2:0]      size;
    logic [2:0]      param;
    logic [SW-1:0]   source;
    logic [AW-1:0]   addr;
    logic [STRB-1:0] mask;
    logic [DW-1:0]   data;
    bit              stable;
    bit              timeout;
    logic            hresp_end;
    logic [DW-1:0]   hrdata_end;
  } obs_t;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [DW-1:0] exp_hrdata = '0;
  logic [AW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [STRB-1:0] model_mask(input logic [AW-1:0] addr, input int size);
    int          off;
    logic [31:0] lanes;
    off   = int'(addr % STRB);
    lanes = (32'd1 << (1 << size)) - 32'd1;
    return STRB'(lanes << off);
  endfunction

  function automatic bit model_legal(input logic [AW-1:0] addr, input int size);
    return ((2 ** size) <= STRB) && ((addr % (2 ** size)) == 0);
  endfunction

  // cycle index (address phase = 0) at which HREADYOUT is seen high again
  function automatic int model_ready(input bit legal, input int a_dly, input int d_dly, input bit derr);
    if (!legal) return 2;
    return 3 + a_dly + d_dly + (derr ? 1 : 0);
  endfunction

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #2;
    end
  endtask

  task automatic drive_addr(input logic [AW-1:0] addr, input logic [2:0] size, input logic wr);
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
    bus.HWRITE = wr;
  endtask

  // Runs the data phase of the transfer whose address phase is being driven now,
  // acting as TL slave; returns in the cycle HREADYOUT is high again.
  task automatic run_data(input logic [DW-1:0] wdata, input int a_dly, input int d_dly,
                          input logic [DW-1:0] rdata, input logic derr, output obs_t o);
    int a_wait = 0;
    int d_wait = 0;
    bit fired = 0;
    bit fired_prev;
    bit d_done = 0;
    o = '0;
    o.stable = 1'b1;
    @(posedge HCLK);
    #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWDATA = wdata;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) begin
        @(posedge HCLK);
        #1;
      end
      #1;
      if (bus.HREADYOUT) begin
        o.ready_cyc  = k;
        o.hresp_end  = bus.HRESP;
        o.hrdata_end = bus.HRDATA;
        if (bus.HRESP) o.resp_hi++;
        bus.a_ready = 1'b0;
        bus.d_valid = 1'b0;
        return;
      end
      o.low_cyc++;
      if (bus.HRESP) o.resp_hi++;
      fired_prev = fired;
      if (bus.a_valid) begin
        o.n_avalid++;
        if (o.n_avalid == 1) begin
          o.opcode = bus.a_opcode;
          o.size   = bus.a_size;
          o.param  = bus.a_param;
          o.source = bus.a_source;
          o.addr   = bus.a_address;
          o.mask   = bus.a_mask;
          o.data   = bus.a_data;
        end else if ({bus.a_opcode, bus.a_size, bus.a_address, bus.a_mask, bus.a_data} !==
                     {o.opcode, o.size, o.addr, o.mask, o.data}) begin
          o.stable = 1'b0;
        end
        bus.a_ready = (a_wait >= a_dly);
        a_wait++;
        if (bus.a_ready) begin
          o.n_fire++;
          fired = 1'b1;
        end
      end else begin
        bus.a_ready = 1'b0;
      end
      if (fired_prev && !d_done) begin
        bus.d_valid  = (d_wait >= d_dly);
        bus.d_data   = rdata;
        bus.d_error  = derr;
        bus.d_opcode = TL_ACCESS_ACK_DATA;
        d_wait++;
        if (bus.d_valid && bus.d_ready) d_done = 1'b1;
      end else begin
        bus.d_valid = 1'b0;
      end
    end
    o.timeout   = 1'b1;
    bus.a_ready = 1'b0;
    bus.d_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #2;
    n_checks++; if (bus.HREADYOUT !== 1'b1) $display("FAIL reset_hreadyout got %0b want 1", bus.HREADYOUT); else n_pass++;
    n_checks++; if (bus.HRESP !== 1'b0) $display("FAIL reset_hresp got %0b want 0", bus.HRESP); else n_pass++;
    n_checks++; if (bus.HRDATA !== '0) $display("FAIL reset_hrdata got %h want 0", bus.HRDATA); else n_pass++;
    n_checks++; if (bus.a_valid !== 1'b0) $display("FAIL reset_a_valid got %0b want 0", bus.a_valid); else n_pass++;
    n_checks++; if (bus.d_ready !== 1'b0) $display("FAIL reset_d_ready got %0b want 0", bus.d_ready); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    HRESETn = 1'b1;
    exp_hrdata = '0;
    idle(1);
  endtask

  task automatic test_read_word();
    obs_t o;
    drive_addr(32'h0000_0010, 3'd2, 1'b0);
    run_data('0, 0, 0, 32'hDEAD_BEEF, 1'b0, o);
    exp_hrdata = 32'hDEAD_BEEF;
    n_checks++; if (o.timeout !== 1'b0) $display("FAIL rd_timeout got %0b want 0", o.timeout); else n_pass++;
    n_checks++; if (o.ready_cyc !== model_ready(1, 0, 0, 0)) $display("FAIL rd_ready_cycle got %0d want %0d", o.ready_cyc, model_ready(1, 0, 0, 0)); else n_pass++;
    n_checks++; if (o.n_fire !== 1) $display("FAIL rd_fires got %0d want 1", o.n_fire); else n_pass++;
    n_checks++; if (o.opcode !== TL_GET) $display("FAIL rd_opcode got %0d want 4", o.opcode); else n_pass++;
    n_checks++; if (o.mask !== 4'b1111) $display("FAIL rd_mask got %b want 1111", o.mask); else n_pass++;
    n_checks++; if (o.addr !== 32'h10) $display("FAIL rd_addr got %h want 10", o.addr); else n_pass++;
    n_checks++; if ({o.size, o.param, o.source} !== {3'd2, 3'd0, 4'd0}) $display("FAIL rd_size_param_source got %h want %h", {o.size, o.param, o.source}, {3'd2, 3'd0, 4'd0}); else n_pass++;
    n_checks++; if (o.hrdata_end !== exp_hrdata) $display("FAIL rd_hrdata got %h want %h", o.hrdata_end, exp_hrdata); else n_pass++;
    n_checks++; if (o.hresp_end !== 1'b0 || o.resp_hi !== 0) $display("FAIL rd_hresp got %0b/%0d want 0/0", o.hresp_end, o.resp_hi); else n_pass++;
  endtask

  task automatic test_byte_write();
    obs_t o;
    drive_addr(32'h0000_0003, 3'd0, 1'b1);
    run_data(32'hAB00_0000, 4, 0, $urandom, 1'b0, o);
    n_checks++; if (o.ready_cyc !== model_ready(1, 4, 0, 0)) $display("FAIL bw_ready_cycle got %0d want %0d", o.ready_cyc, model_ready(1, 4, 0, 0)); else n_pass++;
    n_checks++; if (o.n_avalid !== 5) $display("FAIL bw_avalid_cycles got %0d want 5", o.n_avalid); else n_pass++;
    n_checks++; if (o.stable !== 1'b1) $display("FAIL bw_a_stable got %0b want 1", o.stable); else n_pass++;
    n_checks++; if (o.opcode !== TL_PUT_FULL_DATA) $display("FAIL bw_opcode got %0d want 0", o.opcode); else n_pass++;
    n_checks++; if (o.mask !== model_mask(32'h3, 0)) $display("FAIL bw_mask got %b want %b", o.mask, model_mask(32'h3, 0)); else n_pass++;
    n_checks++; if (o.data !== 32'hAB00_0000) $display("FAIL bw_data got %h want ab000000", o.data); else n_pass++;
    n_checks++; if (o.hrdata_end !== exp_hrdata) $display("FAIL bw_hrdata_hold got %h want %h", o.hrdata_end, exp_hrdata); else n_pass++;
  endtask

  task automatic test_misaligned();
    obs_t o;
    drive_addr(32'h0000_0001, 3'd1, 1'b0);
    run_data('0, 0, 0, $urandom, 1'b0, o);
    n_checks++; if (o.n_avalid !== 0) $display("FAIL mis_a_valid got %0d want 0", o.n_avalid); else n_pass++;
    n_checks++; if (o.ready_cyc !== 2 || o.low_cyc !== 1) $display("FAIL mis_hreadyout got %0d/%0d want 2/1", o.ready_cyc, o.low_cyc); else n_pass++;
    n_checks++; if (o.resp_hi !== 2 || o.hresp_end !== 1'b1) $display("FAIL mis_hresp got %0d/%0b want 2/1", o.resp_hi, o.hresp_end); else n_pass++;
    idle(1);
    n_checks++; if (bus.HRESP !== 1'b0) $display("FAIL mis_hresp_clear got %0b want 0", bus.HRESP); else n_pass++;
  endtask

  task automatic test_d_error();
    obs_t o;
    drive_addr(32'h0000_0008, 3'd2, 1'b0);
    run_data('0, 0, 1, $urandom, 1'b1, o);
    n_checks++; if (o.ready_cyc !== model_ready(1, 0, 1, 1)) $display("FAIL derr_ready_cycle got %0d want %0d", o.ready_cyc, model_ready(1, 0, 1, 1)); else n_pass++;
    n_checks++; if (o.resp_hi !== 2 || o.hresp_end !== 1'b1) $display("FAIL derr_hresp got %0d/%0b want 2/1", o.resp_hi, o.hresp_end); else n_pass++;
    n_checks++; if (o.hrdata_end !== exp_hrdata) $display("FAIL derr_hrdata got %h want %h", o.hrdata_end, exp_hrdata); else n_pass++;
    idle(1);
    n_checks++; if (bus.HRESP !== 1'b0) $display("FAIL derr_hresp_clear got %0b want 0", bus.HRESP); else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_t o0, o1;
    logic [DW-1:0] r0, r1;
    r0 = $urandom;
    r1 = $urandom;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    drive_addr(32'h0, 3'd2, 1'b0);
    run_data('0, 0, 0, r0, 1'b0, o0);
    drive_addr(32'h4, 3'd2, 1'b0);
    run_data('0, 0, 0, r1, 1'b0, o1);
    exp_hrdata = r1;
    n_checks++; if (o0.hrdata_end !== r0) $display("FAIL b2b_data0 got %h want %h", o0.hrdata_end, r0); else n_pass++;
    n_checks++; if (o0.addr !== exp_q.pop_front()) $display("FAIL b2b_addr0 got %h want 0", o0.addr); else n_pass++;
    n_checks++; if (o1.addr !== exp_q.pop_front()) $display("FAIL b2b_addr1 got %h want 4", o1.addr); else n_pass++;
    n_checks++; if (o1.n_fire !== 1 || o1.ready_cyc !== model_ready(1, 0, 0, 0)) $display("FAIL b2b_second got %0d/%0d want 1/%0d", o1.n_fire, o1.ready_cyc, model_ready(1, 0, 0, 0)); else n_pass++;
    n_checks++; if (o1.hrdata_end !== r1) $display("FAIL b2b_data1 got %h want %h", o1.hrdata_end, r1); else n_pass++;
  endtask

  task automatic test_spurious_d();
    bus.d_valid = 1'b1;
    bus.d_data  = $urandom;
    bus.d_error = 1'b0;
    idle(2);
    n_checks++; if (bus.d_ready !== 1'b0) $display("FAIL spur_d_ready got %0b want 0", bus.d_ready); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE || bus.HRDATA !== exp_hrdata) $display("FAIL spur_consumed got %0d/%h want %0d/%h", dbg_state, bus.HRDATA, ST_IDLE, exp_hrdata); else n_pass++;
    bus.d_valid = 1'b0;
    idle(1);
  endtask

  task automatic test_reset_mid();
    drive_addr(32'h0000_0020, 3'd2, 1'b1);
    @(posedge HCLK);
    #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    #1;
    n_checks++; if (bus.a_valid !== 1'b1 || dbg_state !== ST_REQ) $display("FAIL rst_mid_pre got %0b/%0d want 1/%0d", bus.a_valid, dbg_state, ST_REQ); else n_pass++;
    HRESETn = 1'b0;
    @(posedge HCLK);
    #2;
    n_checks++; if (bus.a_valid !== 1'b0) $display("FAIL rst_mid_a_valid got %0b want 0", bus.a_valid); else n_pass++;
    n_checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) $display("FAIL rst_mid_ahb got %0b/%0b want 1/0", bus.HREADYOUT, bus.HRESP); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rst_mid_state got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    HRESETn = 1'b1;
    exp_hrdata = '0;
    idle(1);
  endtask

  task automatic test_random();
    obs_t          o;
    logic [AW-1:0] addr;
    int            size, a_dly, d_dly;
    bit            wr, derr, legal;
    logic [DW-1:0] wdata, rdata;
    for (int t = 0; t < 24; t++) begin
      addr  = AW'($urandom_range(0, 63));
      size  = $urandom_range(0, 3);
      wr    = 1'($urandom_range(0, 1));
      a_dly = $urandom_range(0, 3);
      d_dly = $urandom_range(0, 3);
      derr  = ($urandom_range(0, 4) == 0);
      wdata = $urandom;
      rdata = $urandom;
      legal = model_legal(addr, size);
      idle($urandom_range(0, 1));
      drive_addr(addr, 3'(size), wr);
      run_data(wdata, a_dly, d_dly, rdata, derr, o);
      if (legal && !derr && !wr) exp_hrdata = rdata;
      n_checks++; if (o.timeout !== 1'b0) $display("FAIL rnd%0d_timeout got %0b want 0", t, o.timeout); else n_pass++;
      n_checks++; if (o.ready_cyc !== model_ready(legal, a_dly, d_dly, derr)) $display("FAIL rnd%0d_ready_cycle got %0d want %0d", t, o.ready_cyc, model_ready(legal, a_dly, d_dly, derr)); else n_pass++;
      n_checks++; if (o.low_cyc !== o.ready_cyc - 1) $display("FAIL rnd%0d_wait_states got %0d want %0d", t, o.low_cyc, o.ready_cyc - 1); else n_pass++;
      n_checks++; if (o.resp_hi !== ((legal && !derr) ? 0 : 2)) $display("FAIL rnd%0d_resp_cycles got %0d want %0d", t, o.resp_hi, (legal && !derr) ? 0 : 2); else n_pass++;
      n_checks++; if (o.hrdata_end !== exp_hrdata) $display("FAIL rnd%0d_hrdata got %h want %h", t, o.hrdata_end, exp_hrdata); else n_pass++;
      if (legal) begin
        n_checks++; if (o.n_fire !== 1 || o.stable !== 1'b1) $display("FAIL rnd%0d_fire got %0d/%0b want 1/1", t, o.n_fire, o.stable); else n_pass++;
        n_checks++; if (o.opcode !== (wr ? 3'd0 : 3'd4) || o.addr !== addr || o.size !== 3'(size)) $display("FAIL rnd%0d_a_fields got %0d/%h/%0d want %0d/%h/%0d", t, o.opcode, o.addr, o.size, wr ? 0 : 4, addr, size); else n_pass++;
        n_checks++; if (o.mask !== model_mask(addr, size)) $display("FAIL rnd%0d_mask got %b want %b", t, o.mask, model_mask(addr, size)); else n_pass++;
        if (wr) begin
          n_checks++; if (o.data !== wdata) $display("FAIL rnd%0d_a_data got %h want %h", t, o.data, wdata); else n_pass++;
        end
      end else begin
        n_checks++; if (o.n_avalid !== 0) $display("FAIL rnd%0d_illegal_a_valid got %0d want 0", t, o.n_avalid); else n_pass++;
      end
    end
    idle(1);
  endtask

  initial begin
    bus.HSEL      = 1'b0;
    bus.HADDR     = '0;
    bus.HWDATA    = '0;
    bus.HWRITE    = 1'b0;
    bus.HSIZE     = '0;
    bus.HBURST    = '0;
    bus.HPROT     = '0;
    bus.HTRANS    = HTRANS_IDLE;
    bus.HMASTLOCK = 1'b0;
    bus.a_ready   = 1'b0;
    bus.d_valid   = 1'b0;
    bus.d_opcode  = '0;
    bus.d_data    = '0;
    bus.d_error   = 1'b0;
    test_reset();
    test_read_word();
    test_byte_write();
    test_misaligned();
    test_d_error();
    test_back_to_back();
    test_spurious_d();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no finish by 100000ns want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
